// File: rtl/counter_sequencer.sv
// counter_sequencer: load/run/wrap sequencer that owns an N-bit up-counter.
// A start command latches the terminal value and mode, then the counter
// runs 0..limit and pulses tick for one cycle on each wrap. One-shot runs
// park in DONE after the first wrap; periodic runs reload and keep going.
// All outputs come straight from registers, so no input reaches an output
// combinationally.

module counter_sequencer #(
   parameter int N = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic         abort,
   input  logic         pause,
   input  logic         periodic,
   input  logic [N-1:0] limit,
   output logic [N-1:0] cnt,
   output logic         tick,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [N-1:0] CNT_ZERO = {N{1'b0}};
   localparam logic [N-1:0] CNT_ONE  = N'(1'b1);

   state_t         state_r;
   state_t         state_s;
   logic [N-1:0]   cnt_r;
   logic [N-1:0]   cnt_s;
   logic [N-1:0]   limit_r;
   logic [N-1:0]   limit_s;
   logic           periodic_r;
   logic           periodic_s;
   logic           tick_r;
   logic           tick_s;
   logic           busy_r;
   logic           busy_s;
   logic           done_r;
   logic           done_s;

   // Next-state and next-output decode; abort outranks start, start outranks counting.
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      limit_s    = limit_r;
      periodic_s = periodic_r;
      tick_s     = 1'b0;

      if (abort) begin
         state_s = ST_IDLE;
         cnt_s   = CNT_ZERO;
      end else if (start) begin
         // Restarting from RUN simply abandons the current period without a tick.
         limit_s    = limit;
         periodic_s = periodic;
         cnt_s      = CNT_ZERO;
         state_s    = ST_RUN;
      end else begin
         case (state_r)
            ST_RUN: begin
               if (pause) begin
                  cnt_s = cnt_r;
               end else if (cnt_r == limit_r) begin
                  // Wrap: reload with no gap cycle, or finish a one-shot run.
                  cnt_s  = CNT_ZERO;
                  tick_s = 1'b1;
                  if (periodic_r) begin
                     state_s = ST_RUN;
                  end else begin
                     state_s = ST_DONE;
                  end
               end else begin
                  cnt_s = cnt_r + CNT_ONE;
               end
            end
            ST_IDLE: begin
               cnt_s = CNT_ZERO;
            end
            ST_DONE: begin
               cnt_s = CNT_ZERO;
            end
            default: begin
               // Unreachable encoding: fall back to a safe idle state.
               state_s = ST_IDLE;
               cnt_s   = CNT_ZERO;
            end
         endcase
      end

      busy_s = (state_s == ST_RUN);
      done_s = (state_s == ST_DONE);
   end

   // State and output registers, cleared asynchronously by reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         cnt_r      <= CNT_ZERO;
         limit_r    <= CNT_ZERO;
         periodic_r <= 1'b0;
         tick_r     <= 1'b0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         cnt_r      <= cnt_s;
         limit_r    <= limit_s;
         periodic_r <= periodic_s;
         tick_r     <= tick_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

   assign cnt  = cnt_r;
   assign tick = tick_r;
   assign busy = busy_r;
   assign done = done_r;

endmodule
